l2cache_req_arbiter: RTL and testbench

//  Front-end arbiter/sequencer for the shared L2 cache port. Selects one of four requesters:

---
 rtl/l2_arb_pkg.sv | 28 ++
 rtl/l2_arb_age_ctr.sv | 32 +++
 rtl/l2cache_req_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_l2cache_req_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 request arbiter: source encodings, FSM states
// and the writeback-line hazard compare.
package l2_arb_pkg;

  localparam logic [1:0] SRC_PF = 2'd0;
  localparam logic [1:0] SRC_I  = 2'd1;
  localparam logic [1:0] SRC_DR = 2'd2;
  localparam logic [1:0] SRC_DW = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // 33-bit compare so a line at the very top of the address space cannot wrap.
  function automatic logic in_wb_line(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned line_bytes);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 33'(line_bytes);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/l2_arb_age_ctr.sv
// Saturating starvation counter: counts lost arbitrations, clears on grant,
// flags "boosted" once it reaches LIMIT.
module l2_arb_age_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic boosted
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign boosted = (cnt == LIM);

endmodule

// File: rtl/l2cache_req_arbiter.sv
// Front-end arbiter for the shared L2 port: picks cacop / Dcache / Icache / prefetch,
// holds the grant until L2 accepts, ages I and PF, and blocks Dcache writes into the line being written back.
module l2cache_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LINE_BYTES   = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_req,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_code,
  output logic        op_ack,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic [1:0]  d_size,
  input  logic        d_suc,
  output logic        d_addrok,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_suc,
  output logic        i_addrok,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  input  logic        pf_type,
  output logic        pf_addrok,
  input  logic        wb_valid,
  input  logic [31:0] wb_addr,
  output logic        l2_req,
  output logic        l2_op,
  output logic [1:0]  l2_src,
  output logic [31:0] l2_addr,
  output logic [31:0] l2_wdata,
  output logic [3:0]  l2_wstrb,
  output logic [1:0]  l2_size,
  output logic        l2_suc,
  output logic [31:0] l2_opcode,
  output logic        l2_pftype,
  input  logic        l2_addrok
);

  state_t     state, state_nx;
  logic       grant_op, grant_op_nx;
  logic [1:0] grant_src, grant_src_nx;

  logic       boost_i, boost_pf;
  logic       d_hazard, d_elig;
  logic       win_valid, win_op;
  logic [1:0] win_src;
  logic       win_i, win_pf;
  logic       in_idle, in_grant, accept, pf_withdraw;

  assign in_idle  = (state == IDLE);
  assign in_grant = (state == GRANT);

  assign d_hazard = d_req & d_wr & wb_valid & in_wb_line(d_addr, wb_addr, LINE_BYTES);
  assign d_elig   = d_req & ~d_hazard;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    win_valid = 1'b0;
    win_op    = 1'b0;
    win_src   = SRC_PF;
    if (op_req) begin
      win_valid = 1'b1;
      win_op    = 1'b1;
    end else if (i_req && boost_i) begin
      win_valid = 1'b1;
      win_src   = SRC_I;
    end else if (pf_req && boost_pf) begin
      win_valid = 1'b1;
      win_src   = SRC_PF;
    end else if (d_elig) begin
      win_valid = 1'b1;
      win_src   = d_wr ? SRC_DW : SRC_DR;
    end else if (i_req) begin
      win_valid = 1'b1;
      win_src   = SRC_I;
    end else if (pf_req) begin
      win_valid = 1'b1;
      win_src   = SRC_PF;
    end
  end

  assign win_i  = win_valid & ~win_op & (win_src == SRC_I);
  assign win_pf = win_valid & ~win_op & (win_src == SRC_PF);

  l2_arb_age_ctr #(.LIMIT(STARVE_LIMIT)) u_age_i (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (in_idle & i_req & ~win_i),
    .clr     (in_idle & win_i),
    .boosted (boost_i)
  );

  l2_arb_age_ctr #(.LIMIT(STARVE_LIMIT)) u_age_pf (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (in_idle & pf_req & ~win_pf),
    .clr     (in_idle & win_pf),
    .boosted (boost_pf)
  );

  // A handshake never completes while reset is asserted.
  assign accept      = in_grant & l2_addrok & rstn;
  assign pf_withdraw = in_grant & ~grant_op & (grant_src == SRC_PF) & ~pf_req & ~l2_addrok;

  always_comb begin
    state_nx     = state;
    grant_op_nx  = grant_op;
    grant_src_nx = grant_src;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nx     = GRANT;
          grant_op_nx  = win_op;
          grant_src_nx = win_src;
        end
      end
      GRANT: begin
        if (l2_addrok || pf_withdraw) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      grant_op  <= 1'b0;
      grant_src <= SRC_PF;
    end else begin
      state     <= state_nx;
      grant_op  <= grant_op_nx;
      grant_src <= grant_src_nx;
    end
  end

  assign l2_req    = in_grant;
  assign l2_op     = in_grant & grant_op;
  assign l2_src    = (in_grant && !grant_op) ? grant_src : SRC_PF;

  assign op_ack    = accept & grant_op;
  assign d_addrok  = accept & ~grant_op & grant_src[1];
  assign i_addrok  = accept & ~grant_op & (grant_src == SRC_I);
  assign pf_addrok = accept & ~grant_op & (grant_src == SRC_PF);

  // Payload follows the granted requester live; it holds its inputs until accepted.
  always_comb begin
    l2_addr   = '0;
    l2_wdata  = '0;
    l2_wstrb  = '0;
    l2_size   = '0;
    l2_suc    = 1'b0;
    l2_opcode = '0;
    l2_pftype = 1'b0;
    if (in_grant) begin
      if (grant_op) begin
        l2_addr   = op_addr;
        l2_opcode = op_code;
      end else begin
        case (grant_src)
          SRC_PF: begin
            l2_addr   = pf_addr;
            l2_size   = 2'd2;
            l2_pftype = pf_type;
          end
          SRC_I: begin
            l2_addr = i_addr;
            l2_size = 2'd2;
            l2_suc  = i_suc;
          end
          default: begin
            l2_addr  = d_addr;
            l2_wdata = d_wdata;
            l2_wstrb = d_wstrb;
            l2_size  = d_size;
            l2_suc   = d_suc;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l2cache_req_arbiter.sv
// Directed bench for l2cache_req_arbiter: priority, cacop, aging, writeback hazard,
// prefetch withdraw and reset during a grant.
module tb_l2cache_req_arbiter;

  logic        clk, rstn;
  logic        op_req;  logic [31:0] op_addr, op_code;  logic op_ack;
  logic        d_req, d_wr;  logic [31:0] d_addr, d_wdata;  logic [3:0] d_wstrb;
  logic [1:0]  d_size;  logic d_suc, d_addrok;
  logic        i_req;  logic [31:0] i_addr;  logic i_suc, i_addrok;
  logic        pf_req;  logic [31:0] pf_addr;  logic pf_type, pf_addrok;
  logic        wb_valid;  logic [31:0] wb_addr;
  logic        l2_req, l2_op;  logic [1:0] l2_src;  logic [31:0] l2_addr, l2_wdata;
  logic [3:0]  l2_wstrb;  logic [1:0] l2_size;  logic l2_suc;  logic [31:0] l2_opcode;
  logic        l2_pftype, l2_addrok;

  int n_tests = 0;
  int n_fail  = 0;

  l2cache_req_arbiter #(.STARVE_LIMIT(8), .LINE_BYTES(32)) dut (
    .clk(clk), .rstn(rstn),
    .op_req(op_req), .op_addr(op_addr), .op_code(op_code), .op_ack(op_ack),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_size(d_size), .d_suc(d_suc), .d_addrok(d_addrok),
    .i_req(i_req), .i_addr(i_addr), .i_suc(i_suc), .i_addrok(i_addrok),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_type(pf_type), .pf_addrok(pf_addrok),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .l2_req(l2_req), .l2_op(l2_op), .l2_src(l2_src), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_wstrb(l2_wstrb), .l2_size(l2_size), .l2_suc(l2_suc), .l2_opcode(l2_opcode),
    .l2_pftype(l2_pftype), .l2_addrok(l2_addrok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A granted non-prefetch requester must hold its request until accepted.
  always @(negedge clk) begin
    if (rstn && l2_req) begin
      assert (l2_op ? op_req : ((l2_src == 2'd1) ? i_req : ((l2_src >= 2'd2) ? d_req : 1'b1)))
        else $error("protocol violation: granted request dropped before addrok");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    op_req = 0; op_addr = '0; op_code = '0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_size = '0; d_suc = 0;
    i_req = 0; i_addr = '0; i_suc = 0;
    pf_req = 0; pf_addr = '0; pf_type = 0;
    wb_valid = 0; wb_addr = '0; l2_addrok = 0;
    cyc(); cyc(); settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL reset_l2_req: got %b exp 0", l2_req); end
    n_tests++; if ({l2_op, l2_src} !== 3'b000) begin n_fail++; $display("FAIL reset_op_src: got %b exp 000", {l2_op, l2_src}); end
    n_tests++; if ({op_ack, d_addrok, i_addrok, pf_addrok} !== 4'b0) begin n_fail++; $display("FAIL reset_acks: got %b exp 0000", {op_ack, d_addrok, i_addrok, pf_addrok}); end
    n_tests++; if ({dut.u_age_i.cnt, dut.u_age_pf.cnt} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrs: got %h exp 00", {dut.u_age_i.cnt, dut.u_age_pf.cnt}); end
    cyc();
    rstn = 1'b1;
  endtask

  task automatic test_d_before_i();
    d_req = 1; d_wr = 0; d_addr = 32'h0000_0100; d_size = 2'd1; d_suc = 1;
    i_req = 1; i_addr = 32'h0000_2000; i_suc = 0;
    settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t1_latency: l2_req got %b exp 0", l2_req); end
    cyc(); settle();
    n_tests++; if ({l2_req, l2_src} !== 3'b110) begin n_fail++; $display("FAIL t1_d_first: req/src got %b exp 110", {l2_req, l2_src}); end
    n_tests++; if (l2_addr !== 32'h100 || l2_size !== 2'd1 || l2_suc !== 1'b1) begin n_fail++; $display("FAIL t1_d_payload: addr %h size %0d suc %b exp 100/1/1", l2_addr, l2_size, l2_suc); end
    n_tests++; if (d_addrok !== 1'b0) begin n_fail++; $display("FAIL t1_no_early_ack: d_addrok got %b exp 0", d_addrok); end
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({d_addrok, i_addrok} !== 2'b10) begin n_fail++; $display("FAIL t1_d_ack: d/i addrok got %b exp 10", {d_addrok, i_addrok}); end
    cyc(); d_req = 0; l2_addrok = 0; settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t1_bubble: l2_req got %b exp 0", l2_req); end
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({l2_req, l2_src} !== 3'b101 || l2_addr !== 32'h2000 || l2_size !== 2'd2) begin n_fail++; $display("FAIL t1_i_next: req/src %b addr %h size %0d exp 101/2000/2", {l2_req, l2_src}, l2_addr, l2_size); end
    n_tests++; if (i_addrok !== 1'b1) begin n_fail++; $display("FAIL t1_i_ack: i_addrok got %b exp 1", i_addrok); end
    cyc(); i_req = 0; l2_addrok = 0; settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t1_idle: l2_req got %b exp 0", l2_req); end
  endtask

  task automatic test_cacop();
    cyc();
    op_req = 1; op_addr = 32'h0000_0600; op_code = 32'hDEAD_0001;
    d_req = 1; d_wr = 0; d_addr = 32'h0000_0700;
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({l2_op, l2_src} !== 3'b100 || l2_addr !== 32'h600 || l2_opcode !== 32'hDEAD_0001) begin n_fail++; $display("FAIL t2_op_grant: op/src %b addr %h opcode %h exp 100/600/dead0001", {l2_op, l2_src}, l2_addr, l2_opcode); end
    n_tests++; if ({op_ack, d_addrok} !== 2'b10) begin n_fail++; $display("FAIL t2_op_ack: op_ack/d_addrok got %b exp 10", {op_ack, d_addrok}); end
    cyc(); op_req = 0; l2_addrok = 0; settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t2_bubble: l2_req got %b exp 0", l2_req); end
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({l2_op, l2_src, d_addrok, op_ack} !== 5'b01010) begin n_fail++; $display("FAIL t2_d_after: op/src/dok/opack got %b exp 01010", {l2_op, l2_src, d_addrok, op_ack}); end
    cyc(); d_req = 0; l2_addrok = 0;
  endtask

  task automatic test_aging();
    logic [1:0] exp_src;
    d_req = 1; d_wr = 0; d_addr = 32'h0000_0300;
    i_req = 1; i_addr = 32'h0000_3000;
    l2_addrok = 1;
    for (int r = 1; r <= 10; r++) begin
      settle();
      n_tests++; if ({d_addrok, i_addrok} !== 2'b00) begin n_fail++; $display("FAIL t3_idle_ack r%0d: d/i addrok got %b exp 00", r, {d_addrok, i_addrok}); end
      cyc(); settle();
      exp_src = (r == 9) ? 2'd1 : 2'd2;
      n_tests++; if (l2_src !== exp_src) begin n_fail++; $display("FAIL t3_round r%0d: l2_src got %0d exp %0d", r, l2_src, exp_src); end
      if (r == 9) begin
        n_tests++; if (dut.u_age_i.cnt !== 4'd0) begin n_fail++; $display("FAIL t3_ctr_clear: ctr_i got %0d exp 0", dut.u_age_i.cnt); end
      end
      cyc();
    end
    d_req = 0; i_req = 0; l2_addrok = 0;
    cyc();
  endtask

  task automatic test_wb_hazard();
    wb_valid = 1; wb_addr = 32'h0000_1000;
    d_req = 1; d_wr = 1; d_addr = 32'h0000_101C; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF; d_size = 2'd2;
    i_req = 1; i_addr = 32'h0000_4000;
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({l2_src, i_addrok, d_addrok} !== 4'b0110) begin n_fail++; $display("FAIL t4_blocked_i: src/iok/dok got %b exp 0110", {l2_src, i_addrok, d_addrok}); end
    cyc(); i_req = 0; l2_addrok = 0; d_addr = 32'h0000_1000;
    cyc(); settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t4_base_blocked: l2_req got %b exp 0", l2_req); end
    cyc(); wb_addr = 32'hFFFF_FFE0; d_addr = 32'hFFFF_FFF0;
    cyc(); settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t4_top_line_blocked: l2_req got %b exp 0", l2_req); end
    cyc(); wb_addr = 32'h0000_1000; d_addr = 32'h0000_1020;
    cyc(); l2_addrok = 1; settle();
    n_tests++; if ({l2_req, l2_src, d_addrok} !== 4'b1111) begin n_fail++; $display("FAIL t4_next_line: req/src/dok got %b exp 1111", {l2_req, l2_src, d_addrok}); end
    n_tests++; if (l2_wdata !== 32'hCAFE_F00D || l2_wstrb !== 4'hF || l2_addr !== 32'h1020) begin n_fail++; $display("FAIL t4_dw_payload: wdata %h wstrb %h addr %h exp cafef00d/f/1020", l2_wdata, l2_wstrb, l2_addr); end
    cyc(); d_req = 0; d_wr = 0; wb_valid = 0; l2_addrok = 0;
    cyc();
  endtask

  task automatic test_pf_withdraw();
    pf_req = 1; pf_addr = 32'h0000_5000; pf_type = 1;
    cyc(); settle();
    n_tests++; if ({l2_req, l2_op, l2_src, l2_pftype} !== 5'b10001 || l2_addr !== 32'h5000 || l2_size !== 2'd2) begin n_fail++; $display("FAIL t5_pf_grant: req/op/src/type %b addr %h size %0d exp 10001/5000/2", {l2_req, l2_op, l2_src, l2_pftype}, l2_addr, l2_size); end
    cyc(); pf_req = 0; settle();
    n_tests++; if ({l2_req, pf_addrok} !== 2'b10) begin n_fail++; $display("FAIL t5_drop_cycle: req/pfok got %b exp 10", {l2_req, pf_addrok}); end
    cyc(); settle();
    n_tests++; if ({l2_req, pf_addrok} !== 2'b00) begin n_fail++; $display("FAIL t5_withdrawn: req/pfok got %b exp 00", {l2_req, pf_addrok}); end
    cyc(); settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t5_stays_idle: l2_req got %b exp 0", l2_req); end
    cyc();
  endtask

  task automatic test_reset_mid_grant();
    d_req = 1; d_wr = 0; d_addr = 32'h0000_0800;
    i_req = 1; pf_req = 1;
    cyc(); settle();
    n_tests++; if ({l2_req, l2_src} !== 3'b110) begin n_fail++; $display("FAIL t6_granted: req/src got %b exp 110", {l2_req, l2_src}); end
    n_tests++; if ({dut.u_age_i.cnt, dut.u_age_pf.cnt} !== 8'h11) begin n_fail++; $display("FAIL t6_aged: ctr_i/ctr_pf got %h exp 11", {dut.u_age_i.cnt, dut.u_age_pf.cnt}); end
    cyc(); rstn = 0; l2_addrok = 1; settle();
    n_tests++; if (d_addrok !== 1'b0) begin n_fail++; $display("FAIL t6_no_ack_in_reset: d_addrok got %b exp 0", d_addrok); end
    cyc(); settle();
    n_tests++; if ({l2_req, l2_src} !== 3'b000) begin n_fail++; $display("FAIL t6_req_cleared: req/src got %b exp 000", {l2_req, l2_src}); end
    n_tests++; if ({op_ack, d_addrok, i_addrok, pf_addrok} !== 4'b0) begin n_fail++; $display("FAIL t6_acks: got %b exp 0000", {op_ack, d_addrok, i_addrok, pf_addrok}); end
    n_tests++; if ({dut.u_age_i.cnt, dut.u_age_pf.cnt} !== 8'h00) begin n_fail++; $display("FAIL t6_ctrs: got %h exp 00", {dut.u_age_i.cnt, dut.u_age_pf.cnt}); end
    cyc(); d_req = 0; i_req = 0; pf_req = 0; l2_addrok = 0; rstn = 1;
    cyc(); settle();
    n_tests++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL t6_after: l2_req got %b exp 0", l2_req); end
  endtask

  initial begin
    test_reset();
    test_d_before_i();
    test_cacop();
    test_aging();
    test_wb_hazard();
    test_pf_withdraw();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
